// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA text/hex rendering path.
package vga_pkg;

   localparam int RGB_W     = 8;
   localparam int VISIBLE_H = 384;
   localparam int GLYPH_W   = 8;
   localparam int GLYPH_H   = 8;

   typedef logic [3:0]       nibble_t;
   typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/hex_font_rom.sv
// 8x8 bitmap font for the sixteen hex digits '0'-'9','A'-'F'.
// Purely combinational; the caller registers the selected row.
module hex_font_rom
   import vga_pkg::*;
(
   input  nibble_t    nibble,
   input  logic [2:0] row,
   output logic [7:0] bitmap
);

   logic [63:0] glyph;

   // Row 0 is the top byte; row 7 is left blank in every glyph for line spacing.
   always_comb begin
      glyph = 64'h0;
      case (nibble)
         4'h0: glyph = 64'h3C666E7666663C00;
         4'h1: glyph = 64'h1838181818187E00;
         4'h2: glyph = 64'h3C66060C30607E00;
         4'h3: glyph = 64'h3C66061C06663C00;
         4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
         4'h5: glyph = 64'h7E607C0606663C00;
         4'h6: glyph = 64'h3C607C6666663C00;
         4'h7: glyph = 64'h7E060C1830303000;
         4'h8: glyph = 64'h3C66663C66663C00;
         4'h9: glyph = 64'h3C66663E060C3800;
         4'hA: glyph = 64'h183C66667E666600;
         4'hB: glyph = 64'h7C66667C66667C00;
         4'hC: glyph = 64'h3C66606060663C00;
         4'hD: glyph = 64'h786C6666666C7800;
         4'hE: glyph = 64'h7E60607C60607E00;
         4'hF: glyph = 64'h7E60607C60606000;
      endcase
   end

   assign bitmap = glyph[{~row, 3'b000} +: 8];

endmodule

// File: rtl/hex_word_renderer.sv
// Renders data-memory words as hex glyphs in the column right of the bitmap.
// Three register stages: address/coords, nibble select, font lookup.
module hex_word_renderer
   import vga_pkg::*;
#(
   parameter int         DATA_WIDTH              = 16,
   parameter int         ADDR_WIDTH              = 8,
   parameter int         BITS_PER_MEMORY_PIXEL_Y = 4,
   parameter int         HEX_START_X             = 512,
   parameter int         PIXELS_PER_HEX_DIGIT    = 16,
   parameter int         WORDS_PER_ROW           = 2,
   parameter logic [7:0] FG_RGB                  = 8'hFF
)(
   input  logic                  CLK_50,
   input  logic                  RESET,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  number_drawing_request,
   output logic [7:0]            number_rgb
);

   localparam int DIGITS      = DATA_WIDTH / 4;
   localparam int DIGIT_SHIFT = $clog2(PIXELS_PER_HEX_DIGIT);
   localparam int WORD_SHIFT  = $clog2(DIGITS * PIXELS_PER_HEX_DIGIT);
   localparam int DIGIT_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int GX_SHIFT    = DIGIT_SHIFT - 3;
   localparam int GY_SHIFT    = BITS_PER_MEMORY_PIXEL_Y - 3;

   logic [9:0]            dx;
   logic [9:0]            col;
   logic [9:0]            trow;
   logic                  in_region;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [DIGIT_W-1:0]    digit;
   logic [2:0]            gx;
   logic [2:0]            gy;

   // Left of the column dx wraps to a huge value, so col alone also rejects it.
   assign dx        = pixel_x - 10'(HEX_START_X);
   assign col       = dx >> WORD_SHIFT;
   assign trow      = pixel_y >> BITS_PER_MEMORY_PIXEL_Y;
   assign in_region = (pixel_x >= 10'(HEX_START_X)) && (pixel_y < 10'(VISIBLE_H))
                      && (col < 10'(WORDS_PER_ROW));
   assign addr_next = ADDR_WIDTH'(trow * WORDS_PER_ROW + col);
   assign digit     = DIGIT_W'(dx >> DIGIT_SHIFT);
   assign gx        = 3'(dx >> GX_SHIFT);
   assign gy        = 3'(pixel_y >> GY_SHIFT);

   logic               s0_valid;
   logic [DIGIT_W-1:0] s0_digit;
   logic [2:0]         s0_gx;
   logic [2:0]         s0_gy;

   // The address only moves inside the column so the memory port stays quiet elsewhere.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         mem_addr <= '0;
         s0_valid <= 1'b0;
         s0_digit <= '0;
         s0_gx    <= 3'd0;
         s0_gy    <= 3'd0;
      end else begin
         if (in_region) mem_addr <= addr_next;
         s0_valid <= in_region;
         s0_digit <= digit;
         s0_gx    <= gx;
         s0_gy    <= gy;
      end
   end

   nibble_t nibble_sel;

   // Gate on the valid flag so an undriven memory bus never reaches the font.
   always_comb begin
      nibble_sel = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (s0_valid && (s0_digit == DIGIT_W'(i)))
            nibble_sel = mem_data[DATA_WIDTH-1-4*i -: 4];
      end
   end

   logic    s1_valid;
   nibble_t s1_nibble;
   logic [2:0] s1_gx;
   logic [2:0] s1_gy;

   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         s1_valid  <= 1'b0;
         s1_nibble <= 4'h0;
         s1_gx     <= 3'd0;
         s1_gy     <= 3'd0;
      end else begin
         s1_valid  <= s0_valid;
         s1_nibble <= nibble_sel;
         s1_gx     <= s0_gx;
         s1_gy     <= s0_gy;
      end
   end

   logic [7:0] glyph_row;
   logic       pixel_on;

   hex_font_rom u_font (
      .nibble (s1_nibble),
      .row    (s1_gy),
      .bitmap (glyph_row)
   );

   assign pixel_on = s1_valid & glyph_row[~s1_gx];

   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         number_drawing_request <= 1'b0;
         number_rgb             <= 8'h00;
      end else begin
         number_drawing_request <= pixel_on;
         number_rgb             <= pixel_on ? FG_RGB : 8'h00;
      end
   end

endmodule

// File: tb/tb_hex_word_renderer.sv
// Directed and swept checks of the hex word renderer against hand-worked glyph pixels.
module tb_hex_word_renderer;

   logic        CLK_50;
   logic        RESET;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;
   logic        number_drawing_request;
   logic [7:0]  number_rgb;

   logic [15:0] mem [256];

   int n_compared;
   int n_mismatched;

   hex_word_renderer dut (
      .CLK_50                 (CLK_50),
      .RESET                  (RESET),
      .pixel_x                (pixel_x),
      .pixel_y                (pixel_y),
      .mem_addr               (mem_addr),
      .mem_data               (mem_data),
      .number_drawing_request (number_drawing_request),
      .number_rgb             (number_rgb)
   );

   // Memory registers its address in the DUT; data is seen the following cycle.
   assign mem_data = mem[mem_addr];

   always #10 CLK_50 = ~CLK_50;

   task automatic drive(input int x, input int y);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      @(posedge CLK_50);
      #1;
   endtask

   function automatic logic [7:0] font_row(input int n, input int r);
      logic [63:0] g;
      case (n)
         0:  g = 64'h3C666E7666663C00;
         1:  g = 64'h1838181818187E00;
         2:  g = 64'h3C66060C30607E00;
         3:  g = 64'h3C66061C06663C00;
         4:  g = 64'h0C1C3C6C7E0C0C00;
         5:  g = 64'h7E607C0606663C00;
         6:  g = 64'h3C607C6666663C00;
         7:  g = 64'h7E060C1830303000;
         8:  g = 64'h3C66663C66663C00;
         9:  g = 64'h3C66663E060C3800;
         10: g = 64'h183C66667E666600;
         11: g = 64'h7C66667C66667C00;
         12: g = 64'h3C66606060663C00;
         13: g = 64'h786C6666666C7800;
         14: g = 64'h7E60607C60607E00;
         default: g = 64'h7E60607C60606000;
      endcase
      return g[8*(7-r) +: 8];
   endfunction

   function automatic logic model_on(input int x, input int y);
      int dx, col, addr, d, nib, gxm, gym;
      logic [7:0] rowbits;
      if (x < 512 || y >= 384) return 1'b0;
      dx  = x - 512;
      col = dx / 64;
      if (col >= 2) return 1'b0;
      addr    = ((y / 16) * 2 + col) % 256;
      d       = (dx / 16) % 4;
      nib     = (int'(mem[addr]) / (1 << (4 * (3 - d)))) % 16;
      gxm     = (dx % 16) / 2;
      gym     = (y % 16) / 2;
      rowbits = font_row(nib, gym);
      return rowbits[7-gxm];
   endfunction

   task automatic test_reset();
      RESET = 1'b1;
      drive(520, 20);
      drive(520, 20);
      n_compared++;
      if (mem_addr !== 8'h00) begin
         n_mismatched++;
         $display("[TB] FAIL reset_addr: got %0h expected 0", mem_addr);
      end
      n_compared++;
      if (number_drawing_request !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_req: got %b expected 0", number_drawing_request);
      end
      n_compared++;
      if (number_rgb !== 8'h00) begin
         n_mismatched++;
         $display("[TB] FAIL reset_rgb: got %0h expected 0", number_rgb);
      end
      RESET = 1'b0;
   endtask

   task automatic test_first_word();
      logic [7:0] rb [4];
      logic       e;
      int         p, yy;
      mem[0] = 16'h1234;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            yy = 0;
            rb[0] = 8'h18; rb[1] = 8'h3C; rb[2] = 8'h3C; rb[3] = 8'h0C;
         end else begin
            yy = 2;
            rb[0] = 8'h38; rb[1] = 8'h66; rb[2] = 8'h66; rb[3] = 8'h1C;
         end
         for (int i = 0; i < 66; i++) begin
            if (i < 64) drive(512 + i, yy);
            else        drive(700, 500);
            if (i < 64) begin
               n_compared++;
               if (mem_addr !== 8'h00) begin
                  n_mismatched++;
                  $display("[TB] FAIL word0_addr x=%0d: got %0h expected 0", 512 + i, mem_addr);
               end
            end
            if (i >= 2) begin
               p = i - 2;
               e = rb[p / 16][7 - (p % 16) / 2];
               n_compared++;
               if (number_drawing_request !== e || number_rgb !== (e ? 8'hFF : 8'h00)) begin
                  n_mismatched++;
                  $display("[TB] FAIL word0_pix x=%0d y=%0d: got req=%b rgb=%0h expected req=%b",
                           512 + p, yy, number_drawing_request, number_rgb, e);
               end
            end
         end
      end
   endtask

   task automatic test_address();
      int   xs [4] = '{580, 596, 628, 576};
      logic es [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      mem[3] = 16'hA5C3;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(xs[i], 18);
         else       drive(700, 500);
         if (i < 4) begin
            n_compared++;
            if (mem_addr !== 8'd3) begin
               n_mismatched++;
               $display("[TB] FAIL addr3: got %0d expected 3", mem_addr);
            end
         end
         if (i >= 2) begin
            n_compared++;
            if (number_drawing_request !== es[i-2] || number_rgb !== (es[i-2] ? 8'hFF : 8'h00)) begin
               n_mismatched++;
               $display("[TB] FAIL addr3_pix x=%0d: got req=%b rgb=%0h expected req=%b",
                        xs[i-2], number_drawing_request, number_rgb, es[i-2]);
            end
         end
      end
   endtask

   task automatic test_outside();
      int   xs [4] = '{516, 511, 516, 644};
      int   ys [4] = '{32, 0, 384, 2};
      logic es [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int a = 0; a < 256; a++) mem[a] = 16'hFFFF;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(xs[i], ys[i]);
         else       drive(700, 500);
         n_compared++;
         if (mem_addr !== 8'd4) begin
            n_mismatched++;
            $display("[TB] FAIL outside_addr step=%0d: got %0d expected 4", i, mem_addr);
         end
         if (i >= 2) begin
            n_compared++;
            if (number_drawing_request !== es[i-2] || number_rgb !== (es[i-2] ? 8'hFF : 8'h00)) begin
               n_mismatched++;
               $display("[TB] FAIL outside_pix x=%0d y=%0d: got req=%b rgb=%0h expected req=%b",
                        xs[i-2], ys[i-2], number_drawing_request, number_rgb, es[i-2]);
            end
         end
      end
   endtask

   task automatic test_blank_row();
      logic e;
      mem[0] = 16'h8888;
      for (int i = 0; i < 131; i++) begin
         if (i < 128)       drive(512 + (i % 64), 14 + i / 64);
         else if (i == 128) drive(516, 12);
         else               drive(700, 500);
         if (i >= 2) begin
            e = ((i - 2) == 128);
            n_compared++;
            if (number_drawing_request !== e) begin
               n_mismatched++;
               $display("[TB] FAIL blank_row idx=%0d: got req=%b expected %b",
                        i - 2, number_drawing_request, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic e;
      mem[2] = 16'h1234;
      for (int i = 0; i < 4; i++) drive(530, 18);
      n_compared++;
      if (number_drawing_request !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL pre_reset_req: got %b expected 1", number_drawing_request);
      end
      RESET = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(530, 18);
         n_compared++;
         if (number_drawing_request !== 1'b0 || number_rgb !== 8'h00 || mem_addr !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL in_reset cyc=%0d: got req=%b rgb=%0h addr=%0h expected 0/0/0",
                     i, number_drawing_request, number_rgb, mem_addr);
         end
      end
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(530, 18);
         e = (i == 2);
         n_compared++;
         if (number_drawing_request !== e || number_rgb !== (e ? 8'hFF : 8'h00)) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset cyc=%0d: got req=%b rgb=%0h expected req=%b",
                     i, number_drawing_request, number_rgb, e);
         end
         if (i == 0) begin
            n_compared++;
            if (mem_addr !== 8'd2) begin
               n_mismatched++;
               $display("[TB] FAIL post_reset_addr: got %0d expected 2", mem_addr);
            end
         end
      end
   endtask

   task automatic test_sweep();
      int   qx [$];
      int   qy [$];
      logic e;
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      for (int y = 0; y < 400; y++)
         for (int x = 500; x <= 662; x += 3) begin
            qx.push_back(x);
            qy.push_back(y);
         end
      qx.push_back(798); qy.push_back(524);
      qx.push_back(799); qy.push_back(524);
      qx.push_back(0);   qy.push_back(0);
      qx.push_back(513); qy.push_back(0);
      qx.push_back(514); qy.push_back(1);
      qx.push_back(700); qy.push_back(500);
      qx.push_back(700); qy.push_back(500);
      for (int i = 0; i < qx.size(); i++) begin
         drive(qx[i], qy[i]);
         if (i >= 2) begin
            e = model_on(qx[i-2], qy[i-2]);
            n_compared++;
            if (number_drawing_request !== e || number_rgb !== (e ? 8'hFF : 8'h00)) begin
               n_mismatched++;
               $display("[TB] FAIL sweep x=%0d y=%0d: got req=%b rgb=%0h expected req=%b",
                        qx[i-2], qy[i-2], number_drawing_request, number_rgb, e);
            end
         end
      end
   endtask

   initial begin
      CLK_50       = 1'b0;
      RESET        = 1'b1;
      pixel_x      = 10'd0;
      pixel_y      = 10'd0;
      n_compared   = 0;
      n_mismatched = 0;
      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;

      test_reset();
      test_first_word();
      test_address();
      test_outside();
      test_blank_row();
      test_reset_mid();
      test_sweep();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
